// File: rtl/sp8kb_arb_if.sv
// sp8kb_arb_if: client A/B request-grant-return signals plus the SP8KB pin bundle.
// The arbiter uses the slave modport; clients and the RAM side use master.
interface sp8kb_arb_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 9
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_ad;
  logic [DATA_WIDTH-1:0] a_di;
  logic                  a_gnt;
  logic                  a_dv;
  logic [DATA_WIDTH-1:0] a_do;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_ad;
  logic [DATA_WIDTH-1:0] b_di;
  logic                  b_gnt;
  logic                  b_dv;
  logic [DATA_WIDTH-1:0] b_do;

  logic                  ram_ce;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_ad;
  logic [DATA_WIDTH-1:0] ram_di;
  logic [DATA_WIDTH-1:0] ram_do;

  logic                  busy;

  modport master (
    output a_req, a_we, a_ad, a_di,
    output b_req, b_we, b_ad, b_di,
    output ram_do,
    input  a_gnt, a_dv, a_do,
    input  b_gnt, b_dv, b_do,
    input  ram_ce, ram_we, ram_ad, ram_di,
    input  busy
  );

  modport slave (
    input  a_req, a_we, a_ad, a_di,
    input  b_req, b_we, b_ad, b_di,
    input  ram_do,
    output a_gnt, a_dv, a_do,
    output b_gnt, b_dv, b_do,
    output ram_ce, ram_we, ram_ad, ram_di,
    output busy
  );
endinterface

// File: rtl/sp8kb_arb.sv
// sp8kb_arb: two-client round-robin arbiter and read-return sequencer for one SP8KB port.
// Define SP8KB_ARB_CLEAR_EN to zero-fill the whole RAM after every reset before granting.
module sp8kb_arb #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1
) (
  input logic        clk,
  input logic        rst,
  sp8kb_arb_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  typedef enum logic {CL_A = 1'b0, CL_B = 1'b1} client_e;

`ifdef SP8KB_ARB_CLEAR_EN
  localparam state_e STATE_RST = ST_CLEAR;
`else
  localparam state_e STATE_RST = ST_RUN;
`endif

  state_e                state_q, state_d;
  client_e               last_q, last_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_id_q, pipe_id_d;
  logic                  run;
  logic                  a_win;
  logic                  a_gnt;
  logic                  b_gnt;
  logic                  tail_vld;
  logic                  tail_id;

`ifdef SP8KB_ARB_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clearing;

  assign clearing = (state_q == ST_CLEAR) && !rst;
`endif

  always_comb begin
    state_d = state_q;
`ifdef SP8KB_ARB_CLEAR_EN
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
      if (&clr_addr_q) state_d = ST_RUN;
    end
`else
    state_d = ST_RUN;
`endif
  end

  // Grants are gated by reset so nothing reaches the RAM while RST is high.
  assign run   = (state_q == ST_RUN) && !rst;
  assign a_win = bus.a_req && (!bus.b_req || (last_q == CL_B));
  assign a_gnt = run && a_win;
  assign b_gnt = run && bus.b_req && !a_win;

  assign bus.a_gnt = a_gnt;
  assign bus.b_gnt = b_gnt;

  always_comb begin
    last_d = last_q;
    if (a_gnt)      last_d = CL_A;
    else if (b_gnt) last_d = CL_B;
  end

  always_comb begin
    bus.ram_ce = 1'b0;
    bus.ram_we = 1'b0;
    bus.ram_ad = '0;
    bus.ram_di = '0;
    if (a_gnt) begin
      bus.ram_ce = 1'b1;
      bus.ram_we = bus.a_we;
      bus.ram_ad = bus.a_ad;
      bus.ram_di = bus.a_di;
    end else if (b_gnt) begin
      bus.ram_ce = 1'b1;
      bus.ram_we = bus.b_we;
      bus.ram_ad = bus.b_ad;
      bus.ram_di = bus.b_di;
    end
`ifdef SP8KB_ARB_CLEAR_EN
    else if (clearing) begin
      bus.ram_ce = 1'b1;
      bus.ram_we = 1'b1;
      bus.ram_ad = clr_addr_q;
    end
`endif
  end

`ifdef SP8KB_ARB_CLEAR_EN
  assign bus.busy = (state_q == ST_CLEAR);
`else
  assign bus.busy = 1'b0;
`endif

  // Stage 0 captures the read issued this cycle; the tail lines up with RAM_DO.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_id_d     = pipe_id_q;
    pipe_vld_d[0] = (a_gnt && !bus.a_we) || (b_gnt && !bus.b_we);
    pipe_id_d[0]  = b_gnt;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  assign tail_vld = pipe_vld_q[RD_LATENCY-1];
  assign tail_id  = pipe_id_q[RD_LATENCY-1];

  assign bus.a_dv = tail_vld && !tail_id;
  assign bus.b_dv = tail_vld && tail_id;
  assign bus.a_do = bus.a_dv ? bus.ram_do : '0;
  assign bus.b_do = bus.b_dv ? bus.ram_do : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= STATE_RST;
      last_q     <= CL_B;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
`ifdef SP8KB_ARB_CLEAR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
`ifdef SP8KB_ARB_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sp8kb_arb.sv
// tb_sp8kb_arb: directed bench driving one NOREG (latency 1) and one OUTREG (latency 2)
// arbiter side by side from the same client stimulus, each with its own SP8KB model.
module tb_sp8kb_arb;
  localparam int DW = 18;
  localparam int AW = 9;
`ifdef SP8KB_ARB_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_ad, b_ad;
  logic [DW-1:0] a_di, b_di;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  sp8kb_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
  sp8kb_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if2 ();

  assign if1.a_req = a_req;  assign if2.a_req = a_req;
  assign if1.a_we  = a_we;   assign if2.a_we  = a_we;
  assign if1.a_ad  = a_ad;   assign if2.a_ad  = a_ad;
  assign if1.a_di  = a_di;   assign if2.a_di  = a_di;
  assign if1.b_req = b_req;  assign if2.b_req = b_req;
  assign if1.b_we  = b_we;   assign if2.b_we  = b_we;
  assign if1.b_ad  = b_ad;   assign if2.b_ad  = b_ad;
  assign if1.b_di  = b_di;   assign if2.b_di  = b_di;

  sp8kb_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  sp8kb_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  // SP8KB behaviour: NOREG presents the read word one edge after sampling, OUTREG two.
  logic [DW-1:0] mem1 [2**AW];
  logic [DW-1:0] mem2 [2**AW];
  logic [DW-1:0] rd1   = '0;
  logic [DW-1:0] rd2   = '0;
  logic [DW-1:0] rd2_q = '0;

  always @(posedge clk) begin
    if (if1.ram_ce) begin
      if (if1.ram_we) mem1[if1.ram_ad] <= if1.ram_di;
      else            rd1 <= mem1[if1.ram_ad];
    end
  end

  always @(posedge clk) begin
    if (if2.ram_ce) begin
      if (if2.ram_we) mem2[if2.ram_ad] <= if2.ram_di;
      else            rd2 <= mem2[if2.ram_ad];
    end
    rd2_q <= rd2;
  end

  assign if1.ram_do = rd1;
  assign if2.ram_do = rd2_q;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_we = 1'b0; a_ad = '0; a_di = '0;
    b_req = 1'b0; b_we = 1'b0; b_ad = '0; b_di = '0;
  endtask

  task automatic test_reset();
    int  busy_cycles;
    logic gnt_seen;
    idle_inputs();
    a_req = 1'b1;
    rst   = 1'b1;
    #2;
    vectors++;
    if ({if1.a_gnt, if1.b_gnt, if1.a_dv, if1.b_dv, if1.ram_ce, if1.ram_we} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl_lat1: got %b expected %b",
               {if1.a_gnt, if1.b_gnt, if1.a_dv, if1.b_dv, if1.ram_ce, if1.ram_we}, 6'b0);
    end
    vectors++;
    if ({if2.a_gnt, if2.b_gnt, if2.a_dv, if2.b_dv, if2.ram_ce, if2.ram_we} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl_lat2: got %b expected %b",
               {if2.a_gnt, if2.b_gnt, if2.a_dv, if2.b_dv, if2.ram_ce, if2.ram_we}, 6'b0);
    end
    vectors++;
    if ({if1.ram_ad, if1.ram_di, if1.a_do, if1.b_do} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: got ad=%h di=%h ado=%h bdo=%h expected all 0",
               if1.ram_ad, if1.ram_di, if1.a_do, if1.b_do);
    end
    vectors++;
    if ({if1.busy, if2.busy} !== {BUSY_RST, BUSY_RST}) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b expected %b", {if1.busy, if2.busy}, {BUSY_RST, BUSY_RST});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({if1.a_gnt, if2.a_gnt} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_gnt_gated: got %b expected 00", {if1.a_gnt, if2.a_gnt});
    end
`ifdef SP8KB_ARB_CLEAR_EN
    a_we = 1'b0; a_ad = 9'h1FF;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if1.ram_ce, if1.ram_we, if1.busy, if1.a_gnt, if1.ram_ad, if1.ram_di} !== {4'b1110, 9'h000, 18'h0}) begin
      miscompares++;
      $display("[TB] FAIL clear_first: got ce/we/busy/gnt=%b ad=%h di=%h expected 1110 ad=000 di=0",
               {if1.ram_ce, if1.ram_we, if1.busy, if1.a_gnt}, if1.ram_ad, if1.ram_di);
    end
    busy_cycles = 0;
    gnt_seen    = 1'b0;
    while (if1.busy && busy_cycles < 600) begin
      if (if1.a_gnt || if2.a_gnt) gnt_seen = 1'b1;
      busy_cycles++;
      @(negedge clk);
    end
    vectors++;
    if (busy_cycles !== 512) begin
      miscompares++;
      $display("[TB] FAIL clear_busy_len: got %0d cycles expected 512", busy_cycles);
    end
    vectors++;
    if (gnt_seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clear_no_grant: got %b expected 0", gnt_seen);
    end
    vectors++;
    if ({if1.a_gnt, if1.busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL clear_first_grant: got gnt/busy=%b expected 10", {if1.a_gnt, if1.busy});
    end
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if1.a_dv, if1.a_do} !== {1'b1, 18'h0}) begin
      miscompares++;
      $display("[TB] FAIL clear_read_1ff: got dv=%b do=%h expected dv=1 do=00000", if1.a_dv, if1.a_do);
    end
`else
    a_we = 1'b1; a_ad = 9'h005; a_di = 18'h00055;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if1.a_gnt, if2.a_gnt, if1.busy, if1.ram_ce, if1.ram_we, if1.ram_ad} !== {5'b11011, 9'h005}) begin
      miscompares++;
      $display("[TB] FAIL first_cycle_grant: got gnt/busy/ce/we=%b ad=%h expected 11011 ad=005",
               {if1.a_gnt, if2.a_gnt, if1.busy, if1.ram_ce, if1.ram_we}, if1.ram_ad);
    end
`endif
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_write_read();
    a_req = 1'b1; a_we = 1'b1; a_ad = 9'h010; a_di = 18'h2A5A5;
    @(negedge clk);
    vectors++;
    if ({if1.a_gnt, if1.b_gnt, if1.ram_ce, if1.ram_we, if1.ram_ad, if1.ram_di} !== {4'b1011, 9'h010, 18'h2A5A5}) begin
      miscompares++;
      $display("[TB] FAIL wr_issue: got gnt/ce/we=%b ad=%h di=%h expected 1011 ad=010 di=2a5a5",
               {if1.a_gnt, if1.b_gnt, if1.ram_ce, if1.ram_we}, if1.ram_ad, if1.ram_di);
    end
    next_cycle();
    a_we = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if1.a_gnt, if1.ram_ce, if1.ram_we, if1.a_dv} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL rd_issue: got gnt/ce/we/dv=%b expected 1100", {if1.a_gnt, if1.ram_ce, if1.ram_we, if1.a_dv});
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if ({if1.a_dv, if1.b_dv, if1.a_do, if2.a_dv, if1.ram_ce} !== {2'b10, 18'h2A5A5, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL rd_return_lat1: got dv=%b do=%h lat2dv=%b ce=%b expected dv=10 do=2a5a5 lat2dv=0 ce=0",
               {if1.a_dv, if1.b_dv}, if1.a_do, if2.a_dv, if1.ram_ce);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({if2.a_dv, if2.b_dv, if2.a_do, if1.a_dv, if1.a_do} !== {2'b10, 18'h2A5A5, 1'b0, 18'h0}) begin
      miscompares++;
      $display("[TB] FAIL rd_return_lat2: got dv=%b do=%h lat1dv=%b lat1do=%h expected dv=10 do=2a5a5 lat1dv=0 lat1do=0",
               {if2.a_dv, if2.b_dv}, if2.a_do, if1.a_dv, if1.a_do);
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_round_robin();
    int            p;
    logic          exp_a;
    logic [DW-1:0] exp_data;
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      if (k < 3) begin
        a_req = 1'b1; a_we = 1'b1; a_ad = 9'h020 + 9'(k); a_di = 18'h01000 + 18'(k);
      end else begin
        b_req = 1'b1; b_we = 1'b1; b_ad = 9'h030 + 9'(k-3); b_di = 18'h02000 + 18'(k-3);
      end
      @(negedge clk);
      vectors++;
      if ({if1.a_gnt, if1.b_gnt} !== ((k < 3) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("[TB] FAIL prefill_%0d: got gnt=%b expected %b", k, {if1.a_gnt, if1.b_gnt},
                 (k < 3) ? 2'b10 : 2'b01);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
        a_ad = 9'h020 + 9'((c + 1) / 2);
        b_ad = 9'h030 + 9'(c / 2);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (c < 6) begin
        exp_a = (c % 2 == 0);
        vectors++;
        if ({if1.a_gnt, if1.b_gnt} !== {exp_a, !exp_a}) begin
          miscompares++;
          $display("[TB] FAIL rr_gnt_%0d: got %b expected %b", c, {if1.a_gnt, if1.b_gnt}, {exp_a, !exp_a});
        end
        vectors++;
        if ((if2.a_gnt & if2.b_gnt) !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rr_exclusive_%0d: got both=%b expected 0", c, if2.a_gnt & if2.b_gnt);
        end
      end
      if (c >= 1 && c <= 6) begin
        p        = c - 1;
        exp_a    = (p % 2 == 0);
        exp_data = (exp_a ? 18'h01000 : 18'h02000) + 18'(p / 2);
        vectors++;
        if ({if1.a_dv, if1.b_dv, (exp_a ? if1.a_do : if1.b_do)} !== {exp_a, !exp_a, exp_data}) begin
          miscompares++;
          $display("[TB] FAIL rr_ret_lat1_%0d: got dv=%b ado=%h bdo=%h expected dv=%b data=%h",
                   c, {if1.a_dv, if1.b_dv}, if1.a_do, if1.b_do, {exp_a, !exp_a}, exp_data);
        end
      end
      if (c >= 2) begin
        p        = c - 2;
        exp_a    = (p % 2 == 0);
        exp_data = (exp_a ? 18'h01000 : 18'h02000) + 18'(p / 2);
        vectors++;
        if ({if2.a_dv, if2.b_dv, (exp_a ? if2.a_do : if2.b_do)} !== {exp_a, !exp_a, exp_data}) begin
          miscompares++;
          $display("[TB] FAIL rr_ret_lat2_%0d: got dv=%b ado=%h bdo=%h expected dv=%b data=%h",
                   c, {if2.a_dv, if2.b_dv}, if2.a_do, if2.b_do, {exp_a, !exp_a}, exp_data);
        end
      end
      next_cycle();
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_tie_after_b();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      b_req = 1'b1; b_ad = 9'h030 + 9'(k);
      @(negedge clk);
      vectors++;
      if ({if1.a_gnt, if1.b_gnt} !== 2'b01) begin
        miscompares++;
        $display("[TB] FAIL b_only_%0d: got %b expected 01", k, {if1.a_gnt, if1.b_gnt});
      end
      next_cycle();
    end
    a_req = 1'b1; a_ad = 9'h021; b_ad = 9'h030;
    @(negedge clk);
    vectors++;
    if ({if1.a_gnt, if1.b_gnt, if2.a_gnt, if2.b_gnt} !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL tie_a_wins: got %b expected 1010", {if1.a_gnt, if1.b_gnt, if2.a_gnt, if2.b_gnt});
    end
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if1.b_gnt, if1.a_dv, if1.a_do} !== {2'b11, 18'h01001}) begin
      miscompares++;
      $display("[TB] FAIL tie_b_next: got bgnt=%b adv=%b ado=%h expected 1 1 01001", if1.b_gnt, if1.a_dv, if1.a_do);
    end
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_in_flight();
    logic any_dv;
    idle_inputs();
    a_req = 1'b1; a_ad = 9'h020;
    next_cycle();
    a_req = 1'b0; b_req = 1'b1; b_ad = 9'h031;
    next_cycle();
    b_req = 1'b0; a_req = 1'b1; a_ad = 9'h022;
    #1;
    vectors++;
    if ({if1.b_dv, if2.a_dv} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL inflight_pre: got lat1 bdv/lat2 adv=%b expected 11", {if1.b_dv, if2.a_dv});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({if1.a_dv, if1.b_dv, if2.a_dv, if2.b_dv, if1.a_gnt, if2.a_gnt, if1.ram_ce, if2.ram_ce} !== 8'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_ctl: got %b expected 00000000",
               {if1.a_dv, if1.b_dv, if2.a_dv, if2.b_dv, if1.a_gnt, if2.a_gnt, if1.ram_ce, if2.ram_ce});
    end
    vectors++;
    if ({if1.b_do, if2.a_do, if1.ram_ad, if2.ram_ad, if1.busy} !== {18'h0, 18'h0, 9'h0, 9'h0, BUSY_RST}) begin
      miscompares++;
      $display("[TB] FAIL async_reset_bus: got bdo=%h ado=%h ad=%h/%h busy=%b expected 0 0 0/0 %b",
               if1.b_do, if2.a_do, if1.ram_ad, if2.ram_ad, if1.busy, BUSY_RST);
    end
    a_req = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;
    any_dv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (if1.a_dv || if1.b_dv || if2.a_dv || if2.b_dv) any_dv = 1'b1;
    end
    vectors++;
    if (any_dv !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_dv: got %b expected 0", any_dv);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_tie_after_b();
    test_reset_in_flight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sp8kb_arb.md
# sp8kb_arb

Two-requester round-robin arbiter and sequencer for one single-port 8 Kbit EBR (SP8KB) in registered or non-registered output mode. Two independent clients share the single RAM port through a request/grant handshake, and each client receives read data with a valid strobe at fixed latency. The block sits between client logic and the SP8KB instance and drives its CE/WE/AD/DI pins; CS pins are tied by the parent.

## Interface
- DATA_WIDTH, 18, word width; matches SP8KB DATA_WIDTH.
- ADDR_WIDTH, 9, word address width (512 x 18).
- RD_LATENCY, 1, RAM read latency in cycles: 1 = NOREG, 2 = OUTREG; other values illegal.

- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- A_REQ, B_REQ  in  1  access request; held with fields stable until granted.
- A_WE, B_WE  in  1  1 = write, 0 = read.
- A_AD, B_AD  in  ADDR_WIDTH  word address.
- A_DI, B_DI  in  DATA_WIDTH  write data.
- A_GNT, B_GNT  out  1  access issued this cycle (combinational).
- A_DV, B_DV  out  1  read data valid strobe, one cycle.
- A_DO, B_DO  out  DATA_WIDTH  read data; equals RAM_DO while DVx=1, 0 otherwise.
- RAM_CE, RAM_WE  out  1  to SP8KB CE/WE.
- RAM_AD  out  ADDR_WIDTH  to SP8KB address (LSB-aligned).
- RAM_DI  out  DATA_WIDTH  to SP8KB DI.
- RAM_DO  in  DATA_WIDTH  from SP8KB DO.
- BUSY  out  1  clear sequence running; clients must not expect grants.

## Operation
- At most one access per cycle. GNTx=1 means the RAM samples client x's fields at the closing edge.
- Arbitration:
  - Only one REQ high: that client is granted.
  - Both REQ high: the client not served most recently is granted.
  - A LAST pointer updates on every grant; its reset value is B, so A wins the first tie.
  - A_GNT and B_GNT are never both 1.
- RAM mux:
  - With a grant: RAM_CE=1, and RAM_WE/AD/DI come from the granted client.
  - Without a grant: RAM_CE=0, RAM_WE=0, RAM_AD=0, RAM_DI=0.
- Read return:
  - A shift register RD_LATENCY deep carries {valid, client_id} for each granted read.
  - At the tail, the matching DVx is raised and DOx=RAM_DO.
  - Writes produce no DV.
  - Back-to-back reads from alternating clients return in issue order, one per cycle.
- States: CLEAR (only with macro) -> RUN. In RUN, grants follow the rules above.

## Timing
- Read granted in cycle N: DVx high in cycle N+RD_LATENCY.
- Write granted in cycle N: data visible to a read granted in cycle N+1 or later.
- Reset, asynchronous:
  - GNTx=0, DVx=0, DOx=0, RAM_CE=0, RAM_WE=0, RAM_AD=0, RAM_DI=0.
  - BUSY=1 with the macro, 0 without.
  - LAST=B; the pipeline is flushed, so reads in flight are dropped with no DV.
- GNT is gated low while RST=1.
- A request withdrawn before grant is legal and issues nothing.

## Configuration
- SP8KB_ARB_CLEAR_EN defined:
  - After RST deasserts, the CLEAR state writes 0 to addresses 0 .. 2^ADDR_WIDTH-1, one per cycle.
  - During CLEAR: RAM_CE=1, RAM_WE=1, RAM_DI=0, BUSY=1, no grants.
  - BUSY falls in the cycle after the last address is written; grants start that cycle.
  - Reset during CLEAR restarts the sequence at address 0.
- Not defined: no CLEAR state. BUSY is tied 0, and RUN is entered in the first cycle after reset.

## Test plan
- A writes 0x2A5A5 to address 0x010 (granted cycle N); A reads 0x010 in cycle N+1 -> A_DV high at N+1+RD_LATENCY with A_DO=0x2A5A5, B_DV stays 0.
- A_REQ and B_REQ held high for 6 cycles with reads -> grants A,B,A,B,A,B, each DV in matching order at RD_LATENCY offset, never both GNT high.
- Only B requests for 3 cycles, then both request -> B,B,B then A wins the tie (LAST=B).
- Run with RD_LATENCY=1 and =2 -> read data arrives exactly 1 / 2 cycles after grant respectively.
- RST pulsed while two reads are in flight -> no DV pulses after reset; all outputs at reset values asynchronously.
- With SP8KB_ARB_CLEAR_EN, ADDR_WIDTH=9 -> BUSY high for 512 cycles after reset release, then a read of address 0x1FF returns 0; without the macro, a request in the first cycle after reset is granted.
